// File: rtl/vend_session_ctrl_if.sv
// Pulse inputs and display/payout outputs of the vending session sequencer.
// The master drives the front-end pulses and the slave is the sequencer.
interface vend_session_ctrl_if;
  logic       coin5_pulse;
  logic       coin10_pulse;
  logic       check_pulse;
  logic       count_pulse;
  logic       cancel_pulse;
  logic [2:0] state;
  logic [5:0] credit;
  logic [3:0] qty;
  logic [3:0] max_qty;
  logic       release_led;
  logic       pay10;
  logic       pay5;
  logic       coin_reject;

  modport master (
    output coin5_pulse, coin10_pulse, check_pulse, count_pulse, cancel_pulse,
    input  state, credit, qty, max_qty, release_led, pay10, pay5, coin_reject
  );

  modport slave (
    input  coin5_pulse, coin10_pulse, check_pulse, count_pulse, cancel_pulse,
    output state, credit, qty, max_qty, release_led, pay10, pay5, coin_reject
  );
endinterface

// File: rtl/vend_session_ctrl.sv
// Vending transaction sequencer: deposit with timeout, quantity selection, release,
// and one-coin-per-step change payout. Every output is registered.
module vend_session_ctrl #(
  parameter int MAX_CREDIT  = 50,
  parameter int PRICE       = 5,
  parameter int TIMEOUT_CYC = 18000,
  parameter int RELEASE_CYC = 4,
  parameter int PAYOUT_CYC  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  vend_session_ctrl_if.slave   bus
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_DEPOSIT = 3'd1,
    S_AMOUNT  = 3'd2,
    S_RELEASE = 3'd3,
    S_CHANGE  = 3'd4
  } state_e;

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int RW = $clog2(RELEASE_CYC + 1);
  localparam int PW = $clog2(PAYOUT_CYC + 1);

  localparam logic [5:0]    MAXC     = 6'(MAX_CREDIT);
  localparam logic [5:0]    PRICE_W  = 6'(PRICE);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [RW-1:0] REL_LAST = RW'(RELEASE_CYC - 1);
  localparam logic [PW-1:0] PAY_LAST = PW'(PAYOUT_CYC - 1);

  state_e        state_q, state_d;
  logic [5:0]    credit_q, credit_d;
  logic [3:0]    qty_q, qty_d;
  logic [3:0]    max_qty_q, max_qty_d;
  logic          release_led_q, release_led_d;
  logic          pay10_q, pay10_d;
  logic          pay5_q, pay5_d;
  logic          coin_reject_q, coin_reject_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [RW-1:0] rel_q, rel_d;
  logic [PW-1:0] pay_q, pay_d;

  logic       coin_any;
  logic       any_pulse;
  logic [6:0] sum;

  always_comb begin
    coin_any  = bus.coin5_pulse | bus.coin10_pulse;
    any_pulse = coin_any | bus.check_pulse | bus.count_pulse | bus.cancel_pulse;
    sum       = {1'b0, credit_q} + (bus.coin10_pulse ? 7'd10 : 7'd5);

    state_d       = state_q;
    credit_d      = credit_q;
    qty_d         = qty_q;
    tmo_d         = tmo_q;
    rel_d         = rel_q;
    pay_d         = pay_q;
    pay10_d       = 1'b0;
    pay5_d        = 1'b0;
    coin_reject_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        state_d  = S_DEPOSIT;
        credit_d = '0;
        qty_d    = '0;
        tmo_d    = '0;
        if (coin_any) begin
          credit_d      = bus.coin10_pulse ? 6'd10 : 6'd5;
          coin_reject_d = bus.coin5_pulse & bus.coin10_pulse;
        end
      end

      S_DEPOSIT: begin
        tmo_d = any_pulse ? '0 : tmo_q + 1'b1;
        // A coin that loses to a higher-priority event is not credited, so flag it.
        if (bus.cancel_pulse || tmo_q == TMO_LAST) begin
          state_d       = S_CHANGE;
          pay_d         = '0;
          coin_reject_d = coin_any;
        end else if (bus.check_pulse && credit_q >= PRICE_W) begin
          state_d       = S_AMOUNT;
          qty_d         = max_qty_q;
          coin_reject_d = coin_any;
        end else if (coin_any) begin
          coin_reject_d = (bus.coin5_pulse & bus.coin10_pulse) | (credit_q == MAXC);
          credit_d      = (sum > {1'b0, MAXC}) ? MAXC : sum[5:0];
        end
      end

      S_AMOUNT: begin
        coin_reject_d = coin_any;
        if (bus.cancel_pulse) begin
          state_d = S_CHANGE;
          qty_d   = '0;
          pay_d   = '0;
        end else if (bus.check_pulse) begin
          state_d = S_RELEASE;
          rel_d   = '0;
        end else if (bus.count_pulse) begin
          qty_d = (qty_q <= 4'd1) ? max_qty_q : qty_q - 4'd1;
        end
      end

      S_RELEASE: begin
        coin_reject_d = coin_any;
        if (rel_q == REL_LAST) begin
          state_d  = S_CHANGE;
          credit_d = credit_q - ({2'b00, qty_q} * PRICE_W);
          qty_d    = '0;
          pay_d    = '0;
        end else begin
          rel_d = rel_q + 1'b1;
        end
      end

      S_CHANGE: begin
        coin_reject_d = coin_any;
        if (pay_q == PAY_LAST) begin
          pay_d = '0;
          if (credit_q >= 6'd10) begin
            pay10_d  = 1'b1;
            credit_d = credit_q - 6'd10;
          end else if (credit_q >= 6'd5) begin
            pay5_d   = 1'b1;
            credit_d = credit_q - 6'd5;
          end else begin
            state_d  = S_IDLE;
            credit_d = '0;
          end
        end else begin
          pay_d = pay_q + 1'b1;
        end
      end

      default: begin
        state_d  = S_IDLE;
        credit_d = '0;
        qty_d    = '0;
        tmo_d    = '0;
        rel_d    = '0;
        pay_d    = '0;
      end
    endcase

    max_qty_d     = (state_d == S_DEPOSIT || state_d == S_AMOUNT) ? 4'(credit_d / PRICE_W) : '0;
    release_led_d = (state_d == S_RELEASE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      credit_q      <= '0;
      qty_q         <= '0;
      max_qty_q     <= '0;
      release_led_q <= 1'b0;
      pay10_q       <= 1'b0;
      pay5_q        <= 1'b0;
      coin_reject_q <= 1'b0;
      tmo_q         <= '0;
      rel_q         <= '0;
      pay_q         <= '0;
    end else begin
      state_q       <= state_d;
      credit_q      <= credit_d;
      qty_q         <= qty_d;
      max_qty_q     <= max_qty_d;
      release_led_q <= release_led_d;
      pay10_q       <= pay10_d;
      pay5_q        <= pay5_d;
      coin_reject_q <= coin_reject_d;
      tmo_q         <= tmo_d;
      rel_q         <= rel_d;
      pay_q         <= pay_d;
    end
  end

  assign bus.state       = state_q;
  assign bus.credit      = credit_q;
  assign bus.qty         = qty_q;
  assign bus.max_qty     = max_qty_q;
  assign bus.release_led = release_led_q;
  assign bus.pay10       = pay10_q;
  assign bus.pay5        = pay5_q;
  assign bus.coin_reject = coin_reject_q;

endmodule

// File: tb/tb_vend_session_ctrl.sv
// Directed bench for vend_session_ctrl: coin/quantity/release/change sequences,
// saturation, timeout, wrap-around and mid-payout reset.
module tb_vend_session_ctrl;
  localparam int T_CYC = 20;
  localparam int R_CYC = 3;
  localparam int P_CYC = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  vend_session_ctrl_if bus();

  vend_session_ctrl #(
    .MAX_CREDIT (50),
    .PRICE      (5),
    .TIMEOUT_CYC(T_CYC),
    .RELEASE_CYC(R_CYC),
    .PAYOUT_CYC (P_CYC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int vectors     = 0;
  int miscompares = 0;
  int cyc, n10, n5, both;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic c5, input logic c10, input logic ck, input logic cn, input logic cl);
    bus.coin5_pulse  = c5;
    bus.coin10_pulse = c10;
    bus.check_pulse  = ck;
    bus.count_pulse  = cn;
    bus.cancel_pulse = cl;
    @(posedge clk);
    #1;
    bus.coin5_pulse  = 1'b0;
    bus.coin10_pulse = 1'b0;
    bus.check_pulse  = 1'b0;
    bus.count_pulse  = 1'b0;
    bus.cancel_pulse = 1'b0;
  endtask

  // Steps until IDLE (bounded), tallying payout pulses along the way.
  task automatic run_to_idle(input int bound, output int c, output int p10, output int p5, output int pb);
    c = 0; p10 = 0; p5 = 0; pb = 0;
    while (bus.state !== 3'd0 && c < bound) begin
      @(posedge clk);
      #1;
      c++;
      if (bus.pay10 === 1'b1) p10++;
      if (bus.pay5 === 1'b1) p5++;
      if (bus.pay10 === 1'b1 && bus.pay5 === 1'b1) pb++;
    end
  endtask

  initial begin
    bus.coin5_pulse  = 1'b0;
    bus.coin10_pulse = 1'b0;
    bus.check_pulse  = 1'b0;
    bus.count_pulse  = 1'b0;
    bus.cancel_pulse = 1'b0;

    // Reset state
    step(2);
    chk("rst_state", bus.state, 0);
    chk("rst_credit", bus.credit, 0);
    chk("rst_qty", bus.qty, 0);
    chk("rst_maxqty", bus.max_qty, 0);
    chk("rst_led", bus.release_led, 0);
    chk("rst_pay10", bus.pay10, 0);
    chk("rst_pay5", bus.pay5, 0);
    chk("rst_reject", bus.coin_reject, 0);
    rst = 1'b1;
    step(1);
    chk("idle_to_dep", bus.state, 1);

    // 1: exact purchase, no change
    pulse(0, 1, 0, 0, 0);
    pulse(0, 1, 0, 0, 0);
    pulse(0, 1, 0, 0, 0);
    chk("t1_credit", bus.credit, 30);
    chk("t1_maxqty", bus.max_qty, 6);
    pulse(0, 0, 1, 0, 0);
    chk("t1_amount", bus.state, 2);
    chk("t1_qty", bus.qty, 6);
    pulse(0, 0, 1, 0, 0);
    chk("t1_release", bus.state, 3);
    chk("t1_led", bus.release_led, 1);
    step(R_CYC - 1);
    chk("t1_led_hold", bus.release_led, 1);
    step(1);
    chk("t1_change", bus.state, 4);
    chk("t1_change_amt", bus.credit, 0);
    chk("t1_led_off", bus.release_led, 0);
    chk("t1_qty0", bus.qty, 0);
    run_to_idle(50, cyc, n10, n5, both);
    chk("t1_idle", bus.state, 0);
    chk("t1_cycles", cyc, P_CYC);
    chk("t1_pay10", n10, 0);
    chk("t1_pay5", n5, 0);
    step(1);
    chk("t1_dep", bus.state, 1);

    // 2: qty stepped down, 10 change
    pulse(1, 0, 0, 0, 0);
    pulse(0, 1, 0, 0, 0);
    chk("t2_credit", bus.credit, 15);
    chk("t2_maxqty", bus.max_qty, 3);
    pulse(0, 0, 1, 0, 0);
    chk("t2_qty3", bus.qty, 3);
    pulse(0, 0, 0, 1, 0);
    chk("t2_qty2", bus.qty, 2);
    pulse(0, 0, 0, 1, 0);
    chk("t2_qty1", bus.qty, 1);
    pulse(0, 0, 1, 0, 0);
    chk("t2_release", bus.state, 3);
    step(R_CYC);
    chk("t2_change_amt", bus.credit, 10);
    run_to_idle(100, cyc, n10, n5, both);
    chk("t2_idle", bus.state, 0);
    chk("t2_pay10", n10, 1);
    chk("t2_pay5", n5, 0);
    chk("t2_cycles", cyc, 2 * P_CYC);
    chk("t2_credit0", bus.credit, 0);
    step(1);

    // 3: saturation with partial fill, then cancel refund
    pulse(0, 1, 0, 0, 0);
    pulse(0, 1, 0, 0, 0);
    pulse(0, 1, 0, 0, 0);
    pulse(0, 1, 0, 0, 0);
    pulse(1, 0, 0, 0, 0);
    chk("t3_credit45", bus.credit, 45);
    pulse(0, 1, 0, 0, 0);
    chk("t3_partial", bus.credit, 50);
    chk("t3_partial_rej", bus.coin_reject, 0);
    pulse(0, 1, 0, 0, 0);
    chk("t3_sat_credit", bus.credit, 50);
    chk("t3_sat_rej", bus.coin_reject, 1);
    chk("t3_maxqty", bus.max_qty, 10);
    step(1);
    chk("t3_rej_pulse", bus.coin_reject, 0);
    pulse(0, 0, 0, 0, 1);
    chk("t3_cancel", bus.state, 4);
    chk("t3_change_amt", bus.credit, 50);
    chk("t3_maxqty0", bus.max_qty, 0);
    run_to_idle(100, cyc, n10, n5, both);
    chk("t3_idle", bus.state, 0);
    chk("t3_pay10", n10, 5);
    chk("t3_pay5", n5, 0);
    step(1);

    // 4: check below price ignored; deposit timeout
    pulse(0, 0, 1, 0, 0);
    chk("t4_check_ign", bus.state, 1);
    pulse(1, 0, 0, 0, 0);
    chk("t4_credit", bus.credit, 5);
    cyc = 0;
    while (bus.state !== 3'd4 && cyc < 100) begin
      step(1);
      cyc++;
    end
    chk("t4_timeout_state", bus.state, 4);
    chk("t4_timeout_cyc", cyc, T_CYC);
    chk("t4_change_amt", bus.credit, 5);
    run_to_idle(100, cyc, n10, n5, both);
    chk("t4_idle", bus.state, 0);
    chk("t4_pay5", n5, 1);
    chk("t4_pay10", n10, 0);
    chk("t4_credit0", bus.credit, 0);
    step(1);

    // 5: simultaneous coins, qty wrap, coin in AMOUNT
    pulse(1, 1, 0, 0, 0);
    chk("t5_credit", bus.credit, 10);
    chk("t5_reject", bus.coin_reject, 1);
    chk("t5_maxqty", bus.max_qty, 2);
    pulse(0, 0, 1, 0, 0);
    chk("t5_qty2", bus.qty, 2);
    pulse(0, 0, 0, 1, 0);
    chk("t5_qty1", bus.qty, 1);
    pulse(0, 0, 0, 1, 0);
    chk("t5_wrap", bus.qty, 2);
    pulse(1, 0, 0, 0, 0);
    chk("t5_amt_rej", bus.coin_reject, 1);
    chk("t5_amt_credit", bus.credit, 10);
    pulse(0, 0, 0, 0, 1);
    chk("t5_cancel", bus.state, 4);
    chk("t5_qty0", bus.qty, 0);
    run_to_idle(100, cyc, n10, n5, both);
    chk("t5_idle", bus.state, 0);
    chk("t5_pay10", n10, 1);
    chk("t5_both", both, 0);
    step(1);

    // 6: reset during payout
    pulse(0, 1, 0, 0, 0);
    pulse(0, 1, 0, 0, 0);
    pulse(0, 0, 0, 0, 1);
    step(2);
    chk("t6_mid_state", bus.state, 4);
    chk("t6_mid_credit", bus.credit, 20);
    rst = 1'b0;
    step(1);
    chk("t6_rst_state", bus.state, 0);
    chk("t6_rst_credit", bus.credit, 0);
    chk("t6_rst_pay10", bus.pay10, 0);
    chk("t6_rst_pay5", bus.pay5, 0);
    step(P_CYC);
    chk("t6_hold_pay10", bus.pay10, 0);
    rst = 1'b1;
    step(1);
    chk("t6_dep", bus.state, 1);
    chk("t6_credit0", bus.credit, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
